cordic_mac_scheduler: RTL and testbench

- Shares one iterative CORDIC multiply-accumulate engine among NUM_REQ neuron lanes.
- Lanes are granted round-robin. The scheduler issues one operation to the engine, waits for its done pulse, then returns the result tagged with the lane id.
- Sits between the layer control path (which raises per-lane requests during the compute phase) and the single shared CORDIC MAC datapath.

---
 rtl/cordic_mac_scheduler_pkg.sv | 25 ++
 rtl/cordic_mac_scheduler_rr.sv | 41 ++++
 rtl/cordic_mac_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cordic_mac_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_mac_scheduler_pkg.sv
// Purpose : shared types and constants for the CORDIC MAC scheduler and its engine.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cordic_mac_scheduler_pkg;

  // Scheduler state encoding; the values are shared with debug tooling, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } sched_state_t;

  // Fixed-point operand format shared with the CORDIC MAC engine (signed Q7.8).
  localparam int CORDIC_DATA_W = 16;
  localparam int CORDIC_FRAC_W = 8;
  localparam int CORDIC_INT_W  = CORDIC_DATA_W - CORDIC_FRAC_W;

  // The engine runs one micro-rotation per cycle; the margin covers its
  // operand/result pipeline plus slack, so a healthy engine never times out.
  localparam int CORDIC_ITERS   = 16;
  localparam int TIMEOUT_MARGIN = 24;
  localparam int SCHED_TIMEOUT  = CORDIC_ITERS + TIMEOUT_MARGIN;

endpackage

// File: rtl/cordic_mac_scheduler_rr.sv
// Purpose : round-robin pick of the first set request at or after rr_ptr (with wrap).
// Latency : purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports   : req - request levels; rr_ptr - highest-priority lane;
//           onehot - one-hot winner (0 when no request); idx - winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W:0]   pos;
  logic [ID_W-1:0] lane;
  logic            found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    lane   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr < NUM_REQ and i < NUM_REQ, so one conditional subtract is a full modulo.
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_REQ)) begin
        pos = pos - (ID_W+1)'(NUM_REQ);
      end
      lane = pos[ID_W-1:0];
      if (!found && req[lane]) begin
        found        = 1'b1;
        onehot[lane] = 1'b1;
        idx          = lane;
      end
    end
  end

endmodule

// File: rtl/cordic_mac_scheduler.sv
// Purpose : shares one iterative CORDIC MAC engine among NUM_REQ lanes, round-robin, result tagged with lane id.
// Latency : req at E0 -> gnt after E0, eng_start after E1; eng_done at En -> rsp_valid after En; next grant at En+2.
// Backpressure: one operation in flight; lanes hold req/operands until gnt; engine hang aborted after TIMEOUT cycles.
// Ports   : req/req_x/req_w/req_acc - lane requests and packed operands (lane k at [k*DATA_W +: DATA_W]);
//           gnt - one-hot grant pulse; eng_* - engine handshake and latched operands;
//           rsp_* - tagged result pulse (rsp_err marks a timeout); busy - not IDLE; flush - synchronous abort.
module cordic_mac_scheduler
  import cordic_mac_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CORDIC_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = SCHED_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_w,
  input  logic [NUM_REQ*DATA_W-1:0] req_acc,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_x,
  output logic [DATA_W-1:0]         eng_z,
  output logic [DATA_W-1:0]         eng_y0,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_y,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  // One extra bit so the timer can reach TIMEOUT on the exit cycle without wrapping.
  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_t       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic               eng_start_d;
  logic [DATA_W-1:0]  eng_x_d, eng_z_d, eng_y0_d;
  logic               rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_d;
  logic               rsp_err_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    timer_d     = timer_q;
    gnt_d       = '0;
    eng_start_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    eng_x_d     = eng_x;
    eng_z_d     = eng_z;
    eng_y0_d    = eng_y0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;

    if (flush) begin
      // Abort wherever we are; rr_ptr and latched operands are deliberately kept.
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_d    = arb_onehot;
            eng_x_d  = req_x[arb_idx*DATA_W +: DATA_W];
            eng_z_d  = req_w[arb_idx*DATA_W +: DATA_W];
            eng_y0_d = req_acc[arb_idx*DATA_W +: DATA_W];
            win_d    = arb_idx;
            state_d  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          eng_start_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_WAIT;
        end
        ST_WAIT: begin
          timer_d = timer_q + 1'b1;
          // eng_done is checked first so a completion on the last allowed cycle still counts.
          if (eng_done) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_q;
            rsp_data_d  = eng_y;
            state_d     = ST_RESP;
          end else if (timer_q == TMR_LAST) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_q;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr_d = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      gnt       <= '0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      eng_z     <= '0;
      eng_y0    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      gnt       <= gnt_d;
      eng_start <= eng_start_d;
      eng_x     <= eng_x_d;
      eng_z     <= eng_z_d;
      eng_y0    <= eng_y0_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      // Registered from the next state so busy lines up with the state register.
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cordic_mac_scheduler.sv
// Purpose : randomized scoreboard bench for cordic_mac_scheduler with a behavioural engine model.
// Latency : checks grant, issue and response timing against the documented cycle counts.
// Backpressure: lanes hold req until grant; the engine model chooses when (or whether) to finish.
module tb_cordic_mac_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 40;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_x, req_w, req_acc;
  logic [NUM_REQ-1:0]        gnt;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_x, eng_z, eng_y0;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_y;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      busy;

  always #5 clk = ~clk;

  cordic_mac_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req       (req),
    .req_x     (req_x),
    .req_w     (req_w),
    .req_acc   (req_acc),
    .gnt       (gnt),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_z     (eng_z),
    .eng_y0    (eng_y0),
    .eng_done  (eng_done),
    .eng_y     (eng_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Per-lane operand storage, packed onto the DUT buses.
  logic [DATA_W-1:0] lx [NUM_REQ];
  logic [DATA_W-1:0] lw [NUM_REQ];
  logic [DATA_W-1:0] la [NUM_REQ];

  always_comb begin
    req_x   = '0;
    req_w   = '0;
    req_acc = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_x[k*DATA_W +: DATA_W]   = lx[k];
      req_w[k*DATA_W +: DATA_W]   = lw[k];
      req_acc[k*DATA_W +: DATA_W] = la[k];
    end
  end

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_exp_t;

  rsp_exp_t exp_q[$];
  rsp_exp_t mon_e;

  int total = 0;
  int bad   = 0;
  int m_rr  = 0;   // reference round-robin pointer
  int cur   = 0;   // lane the reference expects to own the current operation
  logic [NUM_REQ-1:0] gnt_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting lane at or after ptr, wrapping around.
  function automatic int model_winner(input logic [NUM_REQ-1:0] m, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // Raise requests, wait for the grant, check it and the issue cycle that follows.
  task automatic begin_op(input logic [NUM_REQ-1:0] mask, input bit rnd, input int exp_lat);
    int cyc;
    bit got;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rnd && mask[k] && !req[k]) begin
        lx[k] = DATA_W'($urandom);
        lw[k] = DATA_W'($urandom);
        la[k] = DATA_W'($urandom);
      end
    end
    req = req | mask;
    cur = model_winner(req, m_rr);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      got = (gnt != '0);
    end
    gnt_seen = gnt;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL gnt_wait: no grant in %0d cycles, expected lane %0d", cyc, cur);
    end
    chk("gnt", 32'(gnt), 32'(1) << cur);
    chk("gnt_lat", cyc, exp_lat);
    chk("busy_on", 32'(busy), 1);
    req = '0;
    @(posedge clk); #1;
    chk("eng_start", 32'(eng_start), 1);
    chk("gnt_pulse", 32'(gnt), 0);
    chk("eng_x", 32'(eng_x), 32'(lx[cur]));
    chk("eng_z", 32'(eng_z), 32'(lw[cur]));
    chk("eng_y0", 32'(eng_y0), 32'(la[cur]));
  endtask

  // Engine model: done 'delay' cycles after eng_start (never if delay <= 0).
  task automatic finish_op(input int delay, input logic [DATA_W-1:0] y);
    rsp_exp_t e;
    int cyc;
    int exp_lat;
    bit got;
    bit ok;
    ok     = (delay > 0) && (delay <= TIMEOUT);
    e.id   = ID_W'(cur);
    e.data = ok ? y : '0;
    e.err  = !ok;
    exp_q.push_back(e);
    exp_lat = ok ? delay : TIMEOUT;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT + 10) begin
      eng_done = (delay > 0) && (cyc + 1 == delay);
      eng_y    = eng_done ? y : DATA_W'($urandom);
      @(posedge clk); #1;
      cyc++;
      got = rsp_valid;
    end
    eng_done = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL rsp_wait: no response in %0d cycles for lane %0d", cyc, cur);
    end
    chk("rsp_lat", cyc, exp_lat);
    m_rr = (cur + 1) % NUM_REQ;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_eng_start"}, 32'(eng_start), 0);
    chk({tag, "_eng_x"}, 32'(eng_x), 0);
    chk({tag, "_eng_z"}, 32'(eng_z), 0);
    chk({tag, "_eng_y0"}, 32'(eng_y0), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Scoreboard monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: id=%0d data=0x%0h err=%0b with nothing outstanding", rsp_id, rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    eng_y    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      lx[k] = '0;
      lw[k] = '0;
      la[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with every lane requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      begin_op(4'b1111, 1'b1, (i == 0) ? 1 : 2);
      chk("rr_order", 32'(gnt_seen), 32'(1) << (i % NUM_REQ));
      finish_op($urandom_range(1, 20), DATA_W'($urandom));
    end

    // Single lane with fixed operands.
    lx[1] = 16'h0100;
    lw[1] = 16'h0080;
    la[1] = 16'h0010;
    begin_op(4'b0010, 1'b0, 2);
    finish_op(16, 16'h0090);

    // Engine hang -> timeout, then a normal operation.
    begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, 2);
    finish_op(-1, '0);
    begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, 2);
    finish_op(8, DATA_W'($urandom));

    // done on the last allowed cycle wins over the timeout.
    begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, 2);
    finish_op(TIMEOUT, 16'h1234);

    // Withdrawal: lane 2 requests while busy, then drops before being granted.
    begin_op(4'b0010, 1'b1, 2);
    for (int k = 2; k < 4; k++) begin
      lx[k] = DATA_W'($urandom);
      lw[k] = DATA_W'($urandom);
      la[k] = DATA_W'($urandom);
    end
    req = 4'b1100;
    finish_op(10, DATA_W'($urandom));
    req = 4'b1000;
    begin_op(4'b1000, 1'b1, 2);
    finish_op(5, DATA_W'($urandom));

    // Stray eng_done while idle.
    repeat (2) begin @(posedge clk); #1; end
    eng_done = 1'b1;
    eng_y    = 16'hBEEF;
    @(posedge clk); #1;
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_rsp", 32'(rsp_valid), 0);
      chk("stray_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end

    // Flush mid-WAIT, then a late eng_done.
    begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, 1);
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_gnt", 32'(gnt), 0);
    chk("flush_start", 32'(eng_start), 0);
    chk("flush_rsp", 32'(rsp_valid), 0);
    eng_done = 1'b1;
    eng_y    = 16'h5A5A;
    @(posedge clk); #1;
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done_rsp", 32'(rsp_valid), 0);
      chk("late_done_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    // Flush keeps the round-robin pointer.
    begin_op(4'b1111, 1'b1, 1);
    finish_op(6, DATA_W'($urandom));

    // Reset mid-WAIT: outputs clear immediately and the pointer returns to lane 0.
    begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, 2);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_rr  = 0;
    begin_op(4'b1111, 1'b1, 1);
    finish_op(3, DATA_W'($urandom));

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      int gap;
      int sel;
      int dly;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      sel = $urandom_range(0, 9);
      dly = (sel == 0) ? -1 : int'($urandom_range(1, 45));
      begin_op(NUM_REQ'($urandom_range(1, 15)), 1'b1, (gap == 0) ? 2 : 1);
      finish_op(dly, DATA_W'($urandom));
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
